// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD controller: runs the power-on init sequence, then turns
// accepted command/data bytes into setup / enable / hold / execution-wait bus timing.
module lcd_hd44780_ctrl #(
    parameter int INIT_EN     = 1,
    parameter int T_PWR_CYC   = 2500000,
    parameter int T_SETUP_CYC = 4,
    parameter int T_EN_CYC    = 12,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 2500,
    parameter int T_CLR_CYC   = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_rs,
    input  logic [7:0]  i_data,
    output logic        o_ready,
    output logic        o_init_done,
    output logic        lcd_on,
    output logic        lcd_en,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data,
    output logic [31:0] o_lcd
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_PWR_CYC, T_SETUP_CYC), max2(T_EN_CYC, T_HOLD_CYC)),
                                max2(T_CMD_CYC, T_CLR_CYC));
    localparam int CNT_W = $clog2(T_MAX + 1);

    // Counters load (duration - 1) and the state ends when they reach zero.
    localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(T_PWR_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR_CYC - 1);

    localparam int          INIT_LEN = 6;
    localparam logic [47:0] INIT_SEQ = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

    typedef enum logic [2:0] {
        ST_PWR, ST_INIT_ISSUE, ST_IDLE, ST_SETUP, ST_EN, ST_HOLD, ST_WAIT
    } state_t;

    localparam state_t ST_RESET = (INIT_EN != 0) ? ST_PWR : ST_IDLE;

    logic [7:0] init_rom [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rom
            if (gi < INIT_LEN) begin : g_used
                assign init_rom[gi] = INIT_SEQ[gi*8 +: 8];
            end else begin : g_pad
                assign init_rom[gi] = 8'h00;
            end
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic             in_init_reg, in_init_next;
    logic             init_done_reg, init_done_next;
    logic             o_ready_reg, o_ready_next;
    logic             lcd_on_reg;
    logic             lcd_en_reg, lcd_en_next;
    logic             lcd_rs_reg, lcd_rs_next;
    logic [7:0]       lcd_data_reg, lcd_data_next;
    logic             is_long_cmd;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    assign is_long_cmd = !lcd_rs_reg && (lcd_data_reg[7:2] == 6'd0) && (lcd_data_reg != 8'h00);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        in_init_next  = in_init_reg;
        lcd_rs_next   = lcd_rs_reg;
        lcd_data_next = lcd_data_reg;

        case (state_reg)
            ST_PWR: begin
                if (cnt_reg == '0) begin
                    state_next = ST_INIT_ISSUE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_INIT_ISSUE: begin
                lcd_rs_next   = 1'b0;
                lcd_data_next = init_rom[idx_reg];
                idx_next      = idx_reg + 3'd1;
                cnt_next      = LD_SETUP;
                state_next    = ST_SETUP;
            end
            ST_IDLE: begin
                if (i_valid && o_ready_reg) begin
                    lcd_rs_next   = i_rs;
                    lcd_data_next = i_data;
                    cnt_next      = LD_SETUP;
                    state_next    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_reg == '0) begin
                    cnt_next   = LD_EN;
                    state_next = ST_EN;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_EN: begin
                if (cnt_reg == '0) begin
                    cnt_next   = LD_HOLD;
                    state_next = ST_HOLD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_reg == '0) begin
                    cnt_next   = is_long_cmd ? LD_CLR : LD_CMD;
                    state_next = ST_WAIT;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else if (in_init_reg && (idx_reg != 3'(INIT_LEN))) begin
                    state_next = ST_INIT_ISSUE;
                end else begin
                    in_init_next = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase

        // Pin registers are loaded from the next state so they line up with it.
        init_done_next = init_done_reg | !in_init_next;
        o_ready_next   = (state_next == ST_IDLE);
        lcd_en_next    = (state_next == ST_EN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RESET;
            cnt_reg       <= LD_PWR;
            idx_reg       <= 3'd0;
            in_init_reg   <= (INIT_EN != 0);
            init_done_reg <= 1'b0;
            o_ready_reg   <= 1'b0;
            lcd_on_reg    <= 1'b0;
            lcd_en_reg    <= 1'b0;
            lcd_rs_reg    <= 1'b0;
            lcd_data_reg  <= 8'h00;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            in_init_reg   <= in_init_next;
            init_done_reg <= init_done_next;
            o_ready_reg   <= o_ready_next;
            lcd_on_reg    <= 1'b1;
            lcd_en_reg    <= lcd_en_next;
            lcd_rs_reg    <= lcd_rs_next;
            lcd_data_reg  <= lcd_data_next;
        end
    end

    assign o_ready     = o_ready_reg;
    assign o_init_done = init_done_reg;
    assign lcd_on      = lcd_on_reg;
    assign lcd_en      = lcd_en_reg;
    assign lcd_rs      = lcd_rs_reg;
    assign lcd_rw      = 1'b0;
    assign lcd_data    = lcd_data_reg;
    assign o_lcd       = {lcd_on_reg, 20'd0, lcd_en_reg, lcd_rs_reg, 1'b0, lcd_data_reg};

endmodule
